// File: rtl/adder_launch_capture_if.sv
// adder_launch_capture_if: operand request and result handshake bundle
interface adder_launch_capture_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  modport master (
    output in_valid, in_a, in_b, in_cin, in_acc, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_acc, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/adder_launch_capture.sv
// adder_launch_capture: launches operands onto a ripple adder, waits for the carry to settle,
// then captures and presents the sum with an optional accumulate feedback path.
module adder_launch_capture #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_launch_capture_if.slave io,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  busy
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  assign io.in_ready  = state == IDLE;
  assign io.out_valid = state == HOLD;
  assign busy         = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      add_a       <= '0;
      add_b       <= '0;
      add_cin     <= 1'b0;
      io.out_sum  <= '0;
      io.out_cout <= 1'b0;
      io.out_ovf  <= 1'b0;
    end else
      case (state)
        IDLE: if (io.in_valid) begin
          add_a   <= io.in_a;
          add_b   <= io.in_acc ? acc : io.in_b;
          add_cin <= io.in_cin;
          cnt     <= CW'(SETTLE_CYCLES - 1);
          state   <= SETTLE;
        end
        // adder inputs are frozen here, so the sampled sum is the settled one
        SETTLE: if (cnt == '0) begin
          io.out_sum  <= add_sum;
          io.out_cout <= add_cout;
          io.out_ovf  <= (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
          acc         <= add_sum;
          state       <= HOLD;
        end else
          cnt <= cnt - CW'(1);
        HOLD: if (io.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_adder_launch_capture.sv
// tb_adder_launch_capture: randomized and directed scoreboard bench with a behavioural adder in place of the gate netlist.
module tb_adder_launch_capture;
  localparam int S = 6;
  logic clk, rst_n;
  logic [7:0] add_a, add_b, add_sum;
  logic add_cin, add_cout, busy;
  adder_launch_capture_if #(.WIDTH(8)) io();
  adder_launch_capture #(.WIDTH(8), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .io(io),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
  );
  assign {add_cout, add_sum} = 9'(add_a) + 9'(add_b) + 9'(add_cin);

  int checks = 0, failures = 0, cyc = 0;
  logic [9:0] exp_q[$];
  int lat_q[$];
  logic [7:0] m_acc = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: samples 1 time unit after the falling edge, stable up to the next rising edge
  logic prev_ov = 1'b0, prev_fire = 1'b0;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_fire = 1'b0;
    end else begin
      if (prev_fire) chk("valid_one_cycle", int'(io.out_valid), 0);
      if (io.out_valid && !prev_ov) begin
        if (lat_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("latency", cyc - lat_q.pop_front(), S);
      end
      prev_fire = io.out_valid && io.out_ready;
      if (prev_fire) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("out_sum", int'(io.out_sum), int'(e[9:2]));
          chk("out_cout", int'(io.out_cout), int'(e[1]));
          chk("out_ovf", int'(io.out_ovf), int'(e[0]));
        end
      end
      prev_ov = io.out_valid;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    m_acc = 8'h00;
    chk("rst_out_valid", int'(io.out_valid), 0);
    chk("rst_in_ready", int'(io.in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_add", int'({add_a, add_b, add_cin}), 0);
    chk("rst_out", int'({io.out_sum, io.out_cout, io.out_ovf}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // issue one request at a falling edge; returns on the falling edge after the accept edge
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic ac,
                    input logic rnd, output int w);
    logic [7:0] bb;
    int s, sv;
    io.in_a = a; io.in_b = b; io.in_cin = c; io.in_acc = ac; io.in_valid = 1'b1;
    w = 0;
    if (rnd) io.out_ready = 1'($urandom_range(0, 1));
    while (!io.in_ready && w < 200) begin
      @(negedge clk);
      w++;
      if (rnd) io.out_ready = 1'($urandom_range(0, 1));
    end
    if (!io.in_ready) begin
      chk("accept_timeout", 1, 0);
      io.in_valid = 1'b0;
      return;
    end
    bb = ac ? m_acc : b;
    s  = int'(a) + int'(bb) + int'(c);
    sv = int'($signed(a)) + int'($signed(bb)) + int'(c);
    exp_q.push_back({s[7:0], s[8], sv > 127 || sv < -128});
    m_acc = s[7:0];
    lat_q.push_back(cyc + 1);
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("launch_a", int'(add_a), int'(a));
    chk("launch_b", int'(add_b), int'(bb));
    chk("launch_cin", int'(add_cin), int'(c));
    chk("busy_in_flight", int'(busy), 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!io.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", int'(io.out_valid), 1);
  endtask

  initial begin
    int w;
    logic [7:0] snap_sum, snap_a, snap_b;
    rst_n = 1'b0;
    io.in_valid = 1'b0; io.in_a = '0; io.in_b = '0; io.in_cin = 1'b0; io.in_acc = 1'b0;
    io.out_ready = 1'b1;
    @(negedge clk);
    do_reset();
    op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, w);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, w);
    op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, w);
    op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, w);
    op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, w);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3; i++) op(8'h05, 8'hAA, 1'b0, 1'b1, 1'b0, w);
    op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, w);
    // backpressure: request held with changing operand while the result waits
    while (busy) @(negedge clk);
    io.out_ready = 1'b0;
    op(8'h21, 8'h43, 1'b1, 1'b0, 1'b0, w);
    wait_valid();
    snap_sum = io.out_sum; snap_a = add_a; snap_b = add_b;
    for (int i = 0; i < 10; i++) begin
      io.in_valid = 1'b1;
      io.in_a = 8'($urandom);
      @(negedge clk);
      chk("bp_valid", int'(io.out_valid), 1);
      chk("bp_in_ready", int'(io.in_ready), 0);
      chk("bp_sum", int'(io.out_sum), int'(snap_sum));
      chk("bp_add_ab", int'({add_a, add_b}), int'({snap_a, snap_b}));
    end
    io.out_ready = 1'b1;
    op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, w);
    chk("bp_accept_wait", w, 1);
    // reset while the counter reads 3
    @(negedge clk);
    @(negedge clk);
    do_reset();
    op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, w);
    op(8'h05, 8'h77, 1'b0, 1'b1, 1'b0, w);
    // reset while a result is held
    while (busy) @(negedge clk);
    io.out_ready = 1'b0;
    op(8'h33, 8'h44, 1'b0, 1'b0, 1'b0, w);
    wait_valid();
    do_reset();
    op(8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, w);
    for (int i = 0; i < 30; i++)
      op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, w);
    io.out_ready = 1'b1;
    for (int n = 0; n < 200 && (exp_q.size() != 0 || io.out_valid); n++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_launch_capture.md
Name: adder_launch_capture

Overview:
- Sequential front/back-end for the gate-level 8-bit ripple adder `dut`.
- Accepts operand pairs over a valid/ready handshake and registers them onto the adder inputs (`ain`/`bin`/`cin`).
- Waits a fixed number of clock cycles for the carry ripple to settle, then captures `sum`/`cout` and presents the result with a valid/ready handshake.
- Provides an accumulate mode that feeds the last captured sum back as operand B.

Parameters:
- WIDTH, 8, operand/sum width; must match the adder instance.
- SETTLE_CYCLES, 6, cycles from launch to capture. Must be >=1 and must cover worst-case adder ripple: about 56 ns at 10 ns clock for WIDTH=8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B; ignored when in_acc=1.
- in_cin  in  1  carry in.
- in_acc  in  1  1: use accumulator register as operand B.
- add_a  out  WIDTH  to adder ain.
- add_b  out  WIDTH  to adder bin.
- add_cin  out  1  to adder cin.
- add_sum  in  WIDTH  from adder sum.
- add_cout  in  1  from adder cout.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  captured sum.
- out_cout  out  1  captured carry out.
- out_ovf  out  1  signed (two's-complement) overflow.
- busy  out  1  operation in flight (state != IDLE).

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - state=IDLE.
  - add_a, add_b, add_cin, out_sum, out_cout, out_ovf, out_valid, accumulator all 0.
  - in_ready=1, busy=0.
- States IDLE, SETTLE, HOLD; in_ready = (state==IDLE).
- IDLE:
  - On rising edge with in_valid=1, load add_a=in_a, add_b = in_acc ? acc : in_b, add_cin=in_cin.
  - Load counter with SETTLE_CYCLES-1 and go to SETTLE.
  - in_valid=0: hold all registers.
- SETTLE:
  - Each edge: counter==0 -> capture, else decrement.
  - Capture: out_sum=add_sum, out_cout=add_cout, acc=add_sum.
  - Capture: out_ovf=(add_a[MSB]==add_b[MSB]) && (add_sum[MSB]!=add_a[MSB]).
  - Capture: out_valid=1, go to HOLD.
  - Capture edge is exactly SETTLE_CYCLES edges after the accept edge; out_valid is visible in the cycle after.
- HOLD:
  - out_valid=1; out_sum, out_cout, out_ovf stable.
  - On edge with out_ready=1: out_valid=0, go to IDLE.
  - out_ready=0: remain indefinitely. No timeout, no result dropped.
- add_a, add_b, add_cin change only on an accept edge.
  - They stay stable through SETTLE and HOLD, so the adder output never changes under a pending capture.
  - Values persist in IDLE until the next accept.
- in_valid outside IDLE is ignored; the upstream must hold the request until in_ready.
- Minimum initiation interval is SETTLE_CYCLES+2 cycles: accept, SETTLE_CYCLES, HOLD with out_ready=1. No overlap between operations.
- Widths:
  - Sum wraps modulo 2^WIDTH; carry reported only via out_cout.
  - acc holds the WIDTH-bit sum only, not the carry.
  - out_ovf is computed from registered launch operands, not from in_*.
- in_acc=1 on the first operation after reset uses acc=0.
- Counter width is clog2(SETTLE_CYCLES+1). SETTLE_CYCLES=1 captures on the edge after accept.
- Reset mid-operation (SETTLE or HOLD): immediate abort, all outputs to reset values, pending result discarded, acc cleared.
- out_valid deasserts asynchronously with rst_n.
- Simultaneous out_ready=1 and in_valid=1 in HOLD: only the result is consumed; the new operand is accepted no earlier than the next cycle (IDLE).

Test Plan:
- Basic add: 10 ns clk, SETTLE_CYCLES=6, in_a=0x0F, in_b=0x01, in_cin=0, out_ready=1.
  - -> out_sum=0x10, out_cout=0, out_ovf=0.
  - -> out_valid rises exactly 6 edges after the accept edge and stays high 1 cycle.
- Worst-case ripple: in_a=0xFF, in_b=0x01, cin=0 -> out_sum=0x00, out_cout=1, out_ovf=0.
  - Repeat with in_a=0xFF, in_b=0x00, cin=1 -> same result.
  - Capture matches the settled gate-level output, with no X/stale value.
- Signed overflow: 0x7F+0x01 -> out_sum=0x80, out_ovf=1, out_cout=0.
  - 0x80+0x80 -> out_sum=0x00, out_cout=1, out_ovf=1.
- Accumulate: after reset, three ops with in_acc=1, in_a=0x05, in_b=0xAA (ignored).
  - -> out_sum 0x05, 0x0A, 0x0F.
  - Then in_acc=0, in_a=0x01, in_b=0x02 -> 0x03.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid with in_valid=1 and changing in_a.
  - -> out_valid, out_sum, add_a, add_b stable; in_ready=0; no operand accepted.
  - Release out_ready -> IDLE next cycle, the pending in_valid is accepted on the following edge.
- Reset mid-SETTLE: assert rst_n=0 at counter=3.
  - -> out_valid=0, add_*=0, busy=0, in_ready=1 immediately.
  - After release, 0x12+0x34 -> out_sum=0x46, and the acc-mode first op uses 0.
